store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered stores (power of two, >=2).
REQ-002 SHALL have parameter AW, default 32, address width.
REQ-003 SHALL have parameter DW, default 32, data width (byte enables = DW/8).
REQ-004 SHALL use one clock; reset is asynchronous and active-low; ports: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-005 SHALL have stValid  in  1  pipeline store request.
REQ-006 SHALL have stAddr  in  AW  store byte address.
REQ-007 SHALL have stData  in  DW  store data.
REQ-008 SHALL have stByteEn  in  DW/8  store byte enables.
REQ-009 SHALL have stReady  out  1  buffer can accept a store.
REQ-010 SHALL have memReq  out  1  write request to data memory.
REQ-011 SHALL have memAddr, memWData, memBE  out  AW/DW/DW/8  head-entry write fields.
REQ-012 SHALL have memAck  in  1  memory accepted current write.
REQ-013 SHALL have ldAddr  in  AW  load address for lookup.
REQ-014 SHALL have ldHit, ldConflict  out  1 each; ldData  out  DW  forwarding result.
REQ-015 SHALL have empty  out  1  no stores pending (fence/drain indicator).

Function
REQ-016 SHALL store entries in FIFO order; push on rising clk when stValid && stReady.
REQ-017 SHALL drive stReady = (count < DEPTH), combinational from count; no push-bypass when full, even if memAck is high the same cycle.
REQ-018 SHALL keep count in $clog2(DEPTH+1) bits; read/write pointers SHALL wrap modulo DEPTH.
REQ-019 SHALL implement drain FSM with states IDLE and REQ.
REQ-020 SHALL, in IDLE with count>0, move to REQ next edge; memReq=1 only in REQ.
REQ-021 SHALL hold memAddr/memWData/memBE stable from the head entry while memReq=1 and memAck=0.
REQ-022 SHALL, in REQ with memAck=1, pop head; stay REQ presenting next entry if count after pop >0, else go IDLE.
REQ-023 SHALL drive memAddr/memWData/memBE to 0 while memReq=0.
REQ-024 SHALL give latency: store pushed into an empty buffer at edge N asserts memReq after edge N+1.
REQ-025 SHALL handle simultaneous push and pop (not full): count unchanged, both pointers advance.
REQ-026 SHALL drive empty = (count==0).
REQ-027 SHALL ignore memAck when memReq=0.

Reset
REQ-028 SHALL, on rst_n low, immediately clear count, pointers, FSM to IDLE; memReq=0, mem outputs=0, stReady=1, empty=1, ldHit=0, ldConflict=0, ldData=0.
REQ-029 SHALL discard all pending entries on reset mid-transaction; no write is re-issued after reset.

Configuration
REQ-030 SHALL compile store-to-load forwarding only when STORE_BUFFER_FORWARD_EN is defined.
REQ-031 SHALL, with macro: compare ldAddr[AW-1:2] against all valid entries combinationally; youngest match wins; ldHit=1, ldData=entry data if its BE all ones; ldConflict=1 if its BE partial; both 0 on no match.
REQ-032 SHALL, without macro: keep all ports; ldHit=0, ldConflict=0, ldData=0; no comparator logic.

Structure
REQ-033 SHALL place in package store_buffer_pkg: entry typedef (addr, data, be), FSM state enum (IDLE, REQ), constant BE_FULL.
REQ-034 SHALL use one sub-module store_buffer_fifo (storage, pointers, count); FSM and forwarding in top.

Verification
REQ-035 SHALL cover: push 0x100/0xDEADBEEF/BE 0xF into empty buffer, memAck held 1 -> memReq high exactly one cycle after push edge, memAddr=0x100, empty=1 after ack.
REQ-036 SHALL cover: 4 pushes, memAck=0 -> stReady=0 after 4th, 5th push dropped, memAddr stable; then ack 4 cycles -> writes in order.
REQ-037 SHALL cover: full buffer, stValid=1 and memAck=1 same cycle -> one pop, no push, count=3.
REQ-038 SHALL cover: rst_n low while memReq=1 with 3 entries -> memReq=0 same cycle, empty=1, no further memReq after release.
REQ-039 SHALL cover (FORWARD_EN): stores 0x200/0x11111111/BE 0xF then 0x200/0x22222222/BE 0xF, ldAddr=0x202 -> ldHit=1, ldData=0x22222222; third store 0x200 BE 0x3 -> ldConflict=1, ldHit=0.
REQ-040 SHALL cover (no macro): same stimulus as REQ-039 -> ldHit=0, ldConflict=0, ldData=0.

Source files
------------

// File: rtl/store_buffer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | store_buffer_pkg : shared entry type, drain FSM states, constants  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package store_buffer_pkg;

  // Entry fields are sized for the widest supported configuration; each
  // instance zero-extends on write and truncates on read to its own AW/DW.
  localparam int SB_MAX_AW  = 64;
  localparam int SB_MAX_DW  = 128;
  localparam int SB_MAX_BEW = SB_MAX_DW / 8;

  typedef struct packed {
    logic [SB_MAX_AW-1:0]  addr;
    logic [SB_MAX_DW-1:0]  data;
    logic [SB_MAX_BEW-1:0] be;
  } sb_entry_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } sb_state_e;

  localparam logic [SB_MAX_BEW-1:0] BE_FULL = '1;

endpackage
`default_nettype wire

// File: rtl/store_buffer_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | store_buffer_fifo : circular store storage with pointers and count |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module store_buffer_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  sb_entry_t     push_entry,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic [PW-1:0] rd_ptr,
  output sb_entry_t     head,
  output sb_entry_t     entries [DEPTH]
);

  sb_entry_t     mem_q [DEPTH];
  sb_entry_t     mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign count   = count_q;
  assign rd_ptr  = rd_ptr_q;
  assign head    = mem_q[rd_ptr_q];
  assign entries = mem_q;

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | store_buffer : FIFO store buffer draining to data memory; optional |
// | store-to-load forwarding when STORE_BUFFER_FORWARD_EN is defined.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stValid,
  input  logic [AW-1:0]   stAddr,
  input  logic [DW-1:0]   stData,
  input  logic [DW/8-1:0] stByteEn,
  output logic            stReady,
  output logic            memReq,
  output logic [AW-1:0]   memAddr,
  output logic [DW-1:0]   memWData,
  output logic [DW/8-1:0] memBE,
  input  logic            memAck,
  input  logic [AW-1:0]   ldAddr,
  output logic            ldHit,
  output logic            ldConflict,
  output logic [DW-1:0]   ldData,
  output logic            empty
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int BEW = DW / 8;

  sb_state_e     state_q;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  sb_entry_t     head;
  sb_entry_t     entries [DEPTH];
  sb_entry_t     push_entry;
  logic          push;
  logic          pop;

  // A full buffer never accepts, even when the head retires this cycle.
  assign stReady = (count < CW'(DEPTH));
  assign push    = stValid && stReady;
  assign pop     = memReq && memAck;
  assign empty   = (count == '0);

  always_comb begin
    push_entry      = '0;
    push_entry.addr = SB_MAX_AW'(stAddr);
    push_entry.data = SB_MAX_DW'(stData);
    push_entry.be   = SB_MAX_BEW'(stByteEn);
  end

  store_buffer_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .rd_ptr     (rd_ptr),
    .head       (head),
    .entries    (entries)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (count != '0) state_q <= REQ;
        REQ:  if (memAck && (count == CW'(1)) && !push) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memReq   = (state_q == REQ);
  assign memAddr  = memReq ? AW'(head.addr)  : '0;
  assign memWData = memReq ? DW'(head.data)  : '0;
  assign memBE    = memReq ? BEW'(head.be)   : '0;

`ifdef STORE_BUFFER_FORWARD_EN
  logic [PW-1:0] fwd_idx;
  logic [AW-1:0] fwd_addr;

  // Scan oldest to youngest so the youngest matching word wins.
  always_comb begin
    ldHit      = 1'b0;
    ldConflict = 1'b0;
    ldData     = '0;
    fwd_idx    = '0;
    fwd_addr   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx  = rd_ptr + PW'(i);
      fwd_addr = AW'(entries[fwd_idx].addr);
      if ((CW'(i) < count) && ((fwd_addr >> 2) == (ldAddr >> 2))) begin
        if (BEW'(entries[fwd_idx].be) == BEW'(BE_FULL)) begin
          ldHit      = 1'b1;
          ldConflict = 1'b0;
          ldData     = DW'(entries[fwd_idx].data);
        end else begin
          ldHit      = 1'b0;
          ldConflict = 1'b1;
          ldData     = '0;
        end
      end
    end
  end
`else
  logic unused_fwd;

  assign ldHit      = 1'b0;
  assign ldConflict = 1'b0;
  assign ldData     = '0;

  always_comb begin
    unused_fwd = ^{ldAddr, rd_ptr};
    for (int i = 0; i < DEPTH; i++) begin
      unused_fwd = unused_fwd ^ (^entries[i]);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_store_buffer : directed self-checking bench for store_buffer;   |
// | load expectations follow STORE_BUFFER_FORWARD_EN.  Rev 1.0         |
// +--------------------------------------------------------------------+
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

`ifdef STORE_BUFFER_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            stValid = 1'b0;
  logic [AW-1:0]   stAddr = '0;
  logic [DW-1:0]   stData = '0;
  logic [DW/8-1:0] stByteEn = '0;
  logic            stReady;
  logic            memReq;
  logic [AW-1:0]   memAddr;
  logic [DW-1:0]   memWData;
  logic [DW/8-1:0] memBE;
  logic            memAck = 1'b0;
  logic [AW-1:0]   ldAddr = '0;
  logic            ldHit;
  logic            ldConflict;
  logic [DW-1:0]   ldData;
  logic            empty;

  int n_pass  = 0;
  int n_total = 0;

  store_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stValid    (stValid),
    .stAddr     (stAddr),
    .stData     (stData),
    .stByteEn   (stByteEn),
    .stReady    (stReady),
    .memReq     (memReq),
    .memAddr    (memAddr),
    .memWData   (memWData),
    .memBE      (memBE),
    .memAck     (memAck),
    .ldAddr     (ldAddr),
    .ldHit      (ldHit),
    .ldConflict (ldConflict),
    .ldData     (ldData),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_store(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] be);
    stValid  = 1'b1;
    stAddr   = a;
    stData   = d;
    stByteEn = be;
    step();
    stValid  = 1'b0;
  endtask

  logic seen_req;

  initial begin
    // Reset state
    #2;
    check_eq("rst_memReq", memReq, 0);
    check_eq("rst_stReady", stReady, 1);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_memAddr", memAddr, 0);
    check_eq("rst_ldHit", ldHit, 0);
    step();
    rst_n = 1'b1;
    step();

    // Single store into empty buffer, memAck held high
    memAck = 1'b1;
    push_store(32'h100, 32'hDEADBEEF, 4'hF);
    check_eq("s1_req_at_push_edge", memReq, 0);
    check_eq("s1_not_empty", empty, 0);
    step();
    check_eq("s1_req_next_edge", memReq, 1);
    check_eq("s1_memAddr", memAddr, 32'h100);
    check_eq("s1_memWData", memWData, 32'hDEADBEEF);
    check_eq("s1_memBE", memBE, 4'hF);
    step();
    check_eq("s1_req_dropped", memReq, 0);
    check_eq("s1_empty_after_ack", empty, 1);
    check_eq("s1_memAddr_zero", memAddr, 0);
    memAck = 1'b0;

    // Fill with memAck low; fifth store must be dropped
    for (int i = 0; i < 4; i++) begin
      push_store(32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
    end
    check_eq("s2_full_stReady", stReady, 0);
    check_eq("s2_head_addr", memAddr, 32'h10);
    push_store(32'h20, 32'hEE, 4'hF);
    check_eq("s2_head_stable", memAddr, 32'h10);
    check_eq("s2_head_data_stable", memWData, 32'hA0);
    memAck = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("s2_drain_addr", memAddr, 32'h10 + 32'(4 * i));
      check_eq("s2_drain_data", memWData, 32'hA0 + 32'(i));
      step();
    end
    memAck = 1'b0;
    check_eq("s2_drained_req", memReq, 0);
    check_eq("s2_drained_empty", empty, 1);

    // Full buffer: push attempt and ack on the same edge
    for (int i = 0; i < 4; i++) begin
      push_store(32'h30 + 32'(4 * i), 32'hB0 + 32'(i), 4'hF);
    end
    check_eq("s3_full", stReady, 0);
    stValid = 1'b1;
    stAddr  = 32'h40;
    stData  = 32'hFF;
    memAck  = 1'b1;
    step();
    stValid = 1'b0;
    check_eq("s3_one_pop_ready", stReady, 1);
    for (int i = 1; i < 4; i++) begin
      check_eq("s3_remaining_addr", memAddr, 32'h30 + 32'(4 * i));
      step();
    end
    memAck = 1'b0;
    check_eq("s3_three_left_empty", empty, 1);
    check_eq("s3_req_low", memReq, 0);

    // Reset while a write is outstanding
    for (int i = 0; i < 3; i++) begin
      push_store(32'h50 + 32'(4 * i), 32'hC0 + 32'(i), 4'hF);
    end
    check_eq("s4_req_before_rst", memReq, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("s4_req_async_clear", memReq, 0);
    check_eq("s4_empty_async", empty, 1);
    check_eq("s4_memAddr_async", memAddr, 0);
    check_eq("s4_stReady_async", stReady, 1);
    step();
    rst_n = 1'b1;
    seen_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen_req = seen_req | memReq;
    end
    check_eq("s4_no_reissue", seen_req, 0);
    check_eq("s4_empty_after", empty, 1);

    // Store-to-load forwarding
    push_store(32'h200, 32'h11111111, 4'hF);
    push_store(32'h200, 32'h22222222, 4'hF);
    ldAddr = 32'h202;
    #1;
    check_eq("s5_hit", ldHit, FWD ? 1 : 0);
    check_eq("s5_data_youngest", ldData, FWD ? 32'h22222222 : 32'h0);
    check_eq("s5_no_conflict", ldConflict, 0);
    push_store(32'h200, 32'h33333333, 4'h3);
    #1;
    check_eq("s5_partial_conflict", ldConflict, FWD ? 1 : 0);
    check_eq("s5_partial_no_hit", ldHit, 0);
    check_eq("s5_partial_data", ldData, 0);
    ldAddr = 32'h300;
    #1;
    check_eq("s5_miss_hit", ldHit, 0);
    check_eq("s5_miss_conflict", ldConflict, 0);
    check_eq("s5_head_addr", memAddr, 32'h200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
